dev_bus_arb: RTL and testbench
==============================

# dev_bus_arb

Two-master arbiter that shares the system bridge's device port (PrAddr/PrWD/PrWrite/PrRD) between the CPU memory-stage load/store path (master 0) and a secondary bus master (master 1, e.g. DMA or debug loader). It grants one transaction at a time through a small state machine with optional wait states. It registers the read data and returns a one-cycle acknowledge to the winning master. It sits between the CPU/secondary master and the bridge; the bridge's address decode and timer devices are unchanged.

## Interface
- `WAIT_CYC`, default 0: extra bus-hold cycles per transaction (0–15).
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `m0_req` in 1: master 0 request. Held with its address/data/we until `m0_ack`.
- `m0_addr` in 30: master 0 word address [31:2].
- `m0_wdata` in 32: master 0 write data.
- `m0_we` in 1: master 0 write (1) / read (0).
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_rdata` out 32: read data, valid while `m0_ack`.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_we`, `m1_ack`, `m1_rdata`: same as master 0, for master 1.
- `PrAddr` out 30: address to bridge.
- `PrWD` out 32: write data to bridge.
- `PrWrite` out 1: write strobe to bridge.
- `PrRD` in 32: read data from bridge (combinational from address).
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, BUS, RESP.
- **IDLE**
  - If no request, stay in IDLE.
  - Otherwise select a winner, latch its index, address, wdata and we into internal registers, and go to BUS.
  - Wait counter loads `WAIT_CYC`.
- **BUS**
  - `PrAddr`, `PrWD` driven from the latched registers.
  - Counter decrements each cycle. When the counter is 0, this is the last BUS cycle:
    - `PrWrite` = latched we.
    - `PrRD` is captured into the read-data register.
    - Next state is RESP.
  - `PrWrite` is never high in any earlier BUS cycle.
- **RESP**
  - Ack is pulsed to the winner only; the rdata register is presented on both `mX_rdata`.
  - Next state is always IDLE.
- **Round-robin (default)**
  - A `last` pointer records the most recently granted master and updates on every grant.
  - When both masters request in IDLE, the master ≠ `last` wins.
- Single requester wins regardless of pointer.
- Outside BUS: `PrAddr`=0, `PrWD`=0, `PrWrite`=0.
- Master dropping `req` mid-transaction: the transaction still completes and ack still pulses (protocol violation, not an error path).
- A master must not re-sample ack as a new request. The arbiter re-arbitrates only in IDLE, so a held `req` after ack starts a new transaction.

## Timing
- Request visible in IDLE at cycle N.
- BUS occupies cycles N+1 .. N+1+`WAIT_CYC`.
- Ack at cycle N+2+`WAIT_CYC`.
- Back in IDLE at N+3+`WAIT_CYC`.
- Minimum period between transactions: 3+`WAIT_CYC` cycles.
- `PrWrite` is high for exactly one cycle per write.
- Reset values:
  - state=IDLE, `last`=1 (master 0 preferred first).
  - counter=0, rdata register=0.
  - all acks 0, `busy`=0, bus outputs 0.
- Reset asserted mid-BUS or mid-RESP aborts immediately:
  - `PrWrite` drops asynchronously.
  - No ack is issued for the aborted transaction.

## Configuration
- `DEV_BUS_ARB_FIXED_PRIO_EN` defined:
  - Master 0 always wins simultaneous requests.
  - `last` pointer is not implemented.
  - Master 1 may starve.
- Not defined: round-robin as above.

## Structure
- Shared package/header: state encodings (IDLE=2'd0, BUS=2'd1, RESP=2'd2), master index constants, `WAIT_CYC` width constant (4 bits).
- One natural sub-module: `rr_pick2`, the two-input round-robin selector. Inputs are the two reqs and `last`; outputs are grant-valid and winner index.
- With the macro defined, `rr_pick2` is replaced by fixed priority inside the same sub-module.

## Test plan
- **Single read, `WAIT_CYC`=0:** m0 reads 0x7f00>>2 with `PrRD`=0x12345678 → `m0_ack` at N+2 with `m0_rdata`=0x12345678; `PrWrite` never high.
- **Single write, `WAIT_CYC`=2:** m1 writes 0xdeadbeef to 0x7f14>>2 → `PrAddr` stable for 3 cycles, `PrWrite` high only in the third, `m1_ack` at N+4.
- **Contention after reset:** both masters request continuously → grants alternate m0, m1, m0, m1, one ack every 3 cycles. With `DEV_BUS_ARB_FIXED_PRIO_EN` defined, all four grants go to m0.
- **Request withdrawal:** m1 drops `req` during BUS → transaction completes, `m1_ack` pulses once, then `busy`=0.
- **Reset mid-write:** `reset` low during the BUS cycle where `PrWrite`=1 → `PrWrite`, `busy` and all acks are 0 immediately, with no ack after release. First post-reset contention grants m0.

Source files
------------

// File: rtl/dev_bus_arb_pkg.sv
// Shared types and constants for the two-master device-port arbiter.
package dev_bus_arb_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        we;
    } xfer_t;

endpackage

// File: rtl/dev_bus_arb_rr_pick2.sv
// Two-input winner selector: round-robin on `last`, or fixed priority to
// master 0 when DEV_BUS_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import dev_bus_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic winner
);

`ifdef DEV_BUS_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt_valid = req0 | req1;
        winner    = req0 ? M0 : M1;
    end
`else
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        gnt_valid = req0 | req1;
        winner    = req0 ? M0 : M1;
        if (req0 && req1) begin
            winner = ~last;
        end
    end
`endif

endmodule

// File: rtl/dev_bus_arb.sv
// Two-master arbiter for the bridge device port (IDLE -> BUS -> RESP).
// Build option: DEV_BUS_ARB_FIXED_PRIO_EN selects fixed priority to master 0.
module dev_bus_arb
    import dev_bus_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [29:0] PrAddr,
    output logic [31:0] PrWD,
    output logic        PrWrite,
    input  logic [31:0] PrRD,
    output logic        busy
);

    state_e              state_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                sel_q;
    logic                we_q;
    logic [31:0]         rdata_q;
    logic                last_ptr;
    logic                gnt_valid;
    logic                winner;
    xfer_t               win_x;

    assign win_x = (winner == M1) ? '{m1_addr, m1_wdata, m1_we}
                                  : '{m0_addr, m0_wdata, m0_we};

    rr_pick2 u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .last      (last_ptr),
        .gnt_valid (gnt_valid),
        .winner    (winner)
    );

`ifdef DEV_BUS_ARB_FIXED_PRIO_EN
    assign last_ptr = M1;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_ptr <= M1;
        end else if (state_q == IDLE && gnt_valid) begin
            last_ptr <= winner;
        end
    end
`endif

    // Bus outputs and acks are registered; reset clears them asynchronously,
    // which is what aborts a write strobe mid-transaction.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= M0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            PrAddr  <= '0;
            PrWD    <= '0;
            PrWrite <= 1'b0;
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        state_q <= BUS;
                        sel_q   <= winner;
                        we_q    <= win_x.we;
                        cnt_q   <= WAIT_W'(WAIT_CYC);
                        PrAddr  <= win_x.addr;
                        PrWD    <= win_x.wdata;
                        PrWrite <= (WAIT_CYC == 0) ? win_x.we : 1'b0;
                        busy    <= 1'b1;
                    end
                end
                BUS: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        rdata_q <= PrRD;
                        PrAddr  <= '0;
                        PrWD    <= '0;
                        PrWrite <= 1'b0;
                        m0_ack  <= (sel_q == M0);
                        m1_ack  <= (sel_q == M1);
                    end else begin
                        cnt_q   <= cnt_q - WAIT_W'(1);
                        // Strobe only in the final BUS cycle.
                        PrWrite <= (cnt_q == WAIT_W'(1)) ? we_q : 1'b0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    PrAddr  <= '0;
                    PrWD    <= '0;
                    PrWrite <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_dev_bus_arb.sv
// Self-checking bench for dev_bus_arb: table-driven vectors on a WAIT_CYC=0
// instance plus hand-written wait-state and reset-abort sequences on WAIT_CYC=2.
module tb_dev_bus_arb;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: WAIT_CYC = 0
    logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
    logic [29:0] a_m0_addr, a_m1_addr;
    logic [31:0] a_m0_wdata, a_m1_wdata, a_prrd;
    logic        a_m0_ack, a_m1_ack, a_prwrite, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_prwd;
    logic [29:0] a_praddr;

    // Instance B: WAIT_CYC = 2
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [29:0] b_m0_addr, b_m1_addr;
    logic [31:0] b_m0_wdata, b_m1_wdata, b_prrd;
    logic        b_m0_ack, b_m1_ack, b_prwrite, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_prwd;
    logic [29:0] b_praddr;

    dev_bus_arb #(.WAIT_CYC(0)) u_dut_a (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_we(a_m0_we),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_we(a_m1_we),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .PrAddr(a_praddr), .PrWD(a_prwd), .PrWrite(a_prwrite), .PrRD(a_prrd),
        .busy(a_busy)
    );

    dev_bus_arb #(.WAIT_CYC(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_we(b_m0_we),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_we(b_m1_we),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .PrAddr(b_praddr), .PrWD(b_prwd), .PrWrite(b_prwrite), .PrRD(b_prrd),
        .busy(b_busy)
    );

    typedef struct {
        logic        m0_req;
        logic [29:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m0_we;
        logic        m1_req;
        logic [29:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        m1_we;
        logic [31:0] prrd;
        logic        ack0;
        logic        ack1;
        logic [31:0] rdata;
        logic [29:0] praddr;
        logic [31:0] prwd;
        logic        prwrite;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, input logic [29:0] ad0, input logic [31:0] wd0, input logic we0,
                       input logic r1, input logic [29:0] ad1, input logic [31:0] wd1, input logic we1,
                       input logic [31:0] rd,
                       input logic k0, input logic k1, input logic [31:0] rdt,
                       input logic [29:0] pa, input logic [31:0] pw, input logic wr, input logic bsy);
        vec_t v;
        v = '{r0, ad0, wd0, we0, r1, ad1, wd1, we1, rd, k0, k1, rdt, pa, pw, wr, bsy};
        vecs.push_back(v);
    endtask

    localparam logic [29:0] A0 = 30'h10;
    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [29:0] A1 = 30'h20;
    localparam logic [31:0] W1 = 32'h2222_2222;
    localparam logic [29:0] RA = 30'h1FC0;
    localparam logic [31:0] RD = 32'h1234_5678;

    task automatic build_table();
        // Contention straight out of reset: m0 (write) and m1 (read) both hold req.
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         0, 0, 32'h0,         30'h0, 32'h0, 0, 0);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'hA000_0001, 0, 0, 32'h0,         A0,    W0,    1, 1);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         1, 0, 32'hA000_0001, 30'h0, 32'h0, 0, 1);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         0, 0, 32'hA000_0001, 30'h0, 32'h0, 0, 0);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'hB000_0002, 0, 0, 32'hA000_0001, A1,    W1,    0, 1);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         0, 1, 32'hB000_0002, 30'h0, 32'h0, 0, 1);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         0, 0, 32'hB000_0002, 30'h0, 32'h0, 0, 0);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'hA000_0003, 0, 0, 32'hB000_0002, A0,    W0,    1, 1);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         1, 0, 32'hA000_0003, 30'h0, 32'h0, 0, 1);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'h0,         0, 0, 32'hA000_0003, 30'h0, 32'h0, 0, 0);
        add(1, A0, W0, 1, 1, A1, W1, 0, 32'hB000_0004, 0, 0, 32'hA000_0003, A1,    W1,    0, 1);
        add(0, 0,  0,  0, 0, 0,  0,  0, 32'h0,         0, 1, 32'hB000_0004, 30'h0, 32'h0, 0, 1);
        add(0, 0,  0,  0, 0, 0,  0,  0, 32'h0,         0, 0, 32'hB000_0004, 30'h0, 32'h0, 0, 0);
        // Single m0 read of 0x7f00>>2.
        add(1, RA, 0, 0, 0, 0, 0, 0, RD, 0, 0, 32'hB000_0004, 30'h0, 32'h0, 0, 0);
        add(1, RA, 0, 0, 0, 0, 0, 0, RD, 0, 0, 32'hB000_0004, RA,    32'h0, 0, 1);
        add(0, 0,  0, 0, 0, 0, 0, 0, RD, 1, 0, RD,            30'h0, 32'h0, 0, 1);
        add(0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, RD,            30'h0, 32'h0, 0, 0);
        // m1 write, req withdrawn during BUS.
        add(0, 0, 0, 0, 1, 30'h2A, 32'h5555_AAAA, 1, 32'h0BAD_BEEF, 0, 0, RD,            30'h0,  32'h0,         0, 0);
        add(0, 0, 0, 0, 0, 30'h2A, 32'h5555_AAAA, 1, 32'h0BAD_BEEF, 0, 0, RD,            30'h2A, 32'h5555_AAAA, 1, 1);
        add(0, 0, 0, 0, 0, 0,      0,             0, 32'h0,         0, 1, 32'h0BAD_BEEF, 30'h0,  32'h0,         0, 1);
        add(0, 0, 0, 0, 0, 0,      0,             0, 32'h0,         0, 0, 32'h0BAD_BEEF, 30'h0,  32'h0,         0, 0);
        add(0, 0, 0, 0, 0, 0,      0,             0, 32'h0,         0, 0, 32'h0BAD_BEEF, 30'h0,  32'h0,         0, 0);
        // m1 alone wins even though the pointer now favours m0.
        add(0, 0, 0, 0, 1, 30'h3, 0, 0, 32'h00C0_FFEE, 0, 0, 32'h0BAD_BEEF, 30'h0, 32'h0, 0, 0);
        add(0, 0, 0, 0, 1, 30'h3, 0, 0, 32'h00C0_FFEE, 0, 0, 32'h0BAD_BEEF, 30'h3, 32'h0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     0, 0, 32'h0,         0, 1, 32'h00C0_FFEE, 30'h0, 32'h0, 0, 1);
        add(0, 0, 0, 0, 0, 0,     0, 0, 32'h0,         0, 0, 32'h00C0_FFEE, 30'h0, 32'h0, 0, 0);
    endtask

    task automatic check_b_idle(input string tag);
        check({tag, "_b_busy"},  {31'h0, b_busy},    32'h0);
        check({tag, "_b_ack0"},  {31'h0, b_m0_ack},  32'h0);
        check({tag, "_b_ack1"},  {31'h0, b_m1_ack},  32'h0);
        check({tag, "_b_prwr"},  {31'h0, b_prwrite}, 32'h0);
        check({tag, "_b_praddr"}, {2'b0, b_praddr},  32'h0);
    endtask

    initial begin
        {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
        {a_m0_addr, a_m1_addr} = '0;
        {a_m0_wdata, a_m1_wdata, a_prrd} = '0;
        {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
        {b_m0_addr, b_m1_addr} = '0;
        {b_m0_wdata, b_m1_wdata, b_prrd} = '0;
        build_table();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_busy",  {31'h0, a_busy},    32'h0);
        check("rst_a_ack0",  {31'h0, a_m0_ack},  32'h0);
        check("rst_a_ack1",  {31'h0, a_m1_ack},  32'h0);
        check("rst_a_prwr",  {31'h0, a_prwrite}, 32'h0);
        check("rst_a_praddr", {2'b0, a_praddr},  32'h0);
        check("rst_a_prwd",  a_prwd,             32'h0);
        check("rst_a_rdata0", a_m0_rdata,        32'h0);
        check("rst_a_rdata1", a_m1_rdata,        32'h0);
        check_b_idle("rst");
        reset = 1'b1;

        // Table-driven vectors on instance A
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_m0_req   = vecs[i].m0_req;
            a_m0_addr  = vecs[i].m0_addr;
            a_m0_wdata = vecs[i].m0_wdata;
            a_m0_we    = vecs[i].m0_we;
            a_m1_req   = vecs[i].m1_req;
            a_m1_addr  = vecs[i].m1_addr;
            a_m1_wdata = vecs[i].m1_wdata;
            a_m1_we    = vecs[i].m1_we;
            a_prrd     = vecs[i].prrd;
            #1;
            check($sformatf("v%0d_ack0", i),   {31'h0, a_m0_ack},  {31'h0, vecs[i].ack0});
            check($sformatf("v%0d_ack1", i),   {31'h0, a_m1_ack},  {31'h0, vecs[i].ack1});
            check($sformatf("v%0d_rdata0", i), a_m0_rdata,         vecs[i].rdata);
            check($sformatf("v%0d_rdata1", i), a_m1_rdata,         vecs[i].rdata);
            check($sformatf("v%0d_praddr", i), {2'b0, a_praddr},   {2'b0, vecs[i].praddr});
            check($sformatf("v%0d_prwd", i),   a_prwd,             vecs[i].prwd);
            check($sformatf("v%0d_prwr", i),   {31'h0, a_prwrite}, {31'h0, vecs[i].prwrite});
            check($sformatf("v%0d_busy", i),   {31'h0, a_busy},    {31'h0, vecs[i].busy});
        end

        // Instance B: m1 writes 0xdeadbeef to 0x7f14>>2 with two wait states
        begin
            logic [5:0] exp_wr, exp_ack1, exp_busy, exp_bus;
            exp_wr   = 6'b001000;
            exp_ack1 = 6'b010000;
            exp_busy = 6'b011110;
            exp_bus  = 6'b001110;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    b_m1_req = 1'b1; b_m1_addr = 30'h1FC5; b_m1_wdata = 32'hDEAD_BEEF; b_m1_we = 1'b1;
                end
                if (k == 4) b_m1_req = 1'b0;
                #1;
                check($sformatf("wr%0d_prwr", k), {31'h0, b_prwrite}, {31'h0, exp_wr[k]});
                check($sformatf("wr%0d_ack1", k), {31'h0, b_m1_ack},  {31'h0, exp_ack1[k]});
                check($sformatf("wr%0d_ack0", k), {31'h0, b_m0_ack},  32'h0);
                check($sformatf("wr%0d_busy", k), {31'h0, b_busy},    {31'h0, exp_busy[k]});
                check($sformatf("wr%0d_praddr", k), {2'b0, b_praddr}, exp_bus[k] ? {2'b0, 30'h1FC5} : 32'h0);
                check($sformatf("wr%0d_prwd", k), b_prwd, exp_bus[k] ? 32'hDEAD_BEEF : 32'h0);
            end
        end

        // Instance B: reset asserted in the strobe cycle of an m0 write
        @(negedge clk);
        b_m0_req = 1'b1; b_m0_addr = 30'h44; b_m0_wdata = 32'h77; b_m0_we = 1'b1;
        @(negedge clk);
        check("ab1_prwr", {31'h0, b_prwrite}, 32'h0);
        @(negedge clk);
        check("ab2_prwr", {31'h0, b_prwrite}, 32'h0);
        @(negedge clk);
        check("ab3_prwr", {31'h0, b_prwrite}, 32'h1);
        check("ab3_busy", {31'h0, b_busy},    32'h1);
        #2;
        reset = 1'b0;
        b_m0_req = 1'b0;
        #1;
        check_b_idle("abrt");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check_b_idle($sformatf("post%0d", k));
        end

        // First contention after reset must go to m0
        @(negedge clk);
        b_m0_req = 1'b1; b_m0_addr = 30'h50; b_m0_we = 1'b0;
        b_m1_req = 1'b1; b_m1_addr = 30'h60; b_m1_we = 1'b0;
        @(negedge clk);
        #1;
        check("pc_praddr", {2'b0, b_praddr}, {2'b0, 30'h50});
        repeat (3) @(negedge clk);
        #1;
        check("pc_ack0", {31'h0, b_m0_ack}, 32'h1);
        check("pc_ack1", {31'h0, b_m1_ack}, 32'h0);
        b_m0_req = 1'b0;
        b_m1_req = 1'b0;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
